// File: rtl/sal_dispatcher_rr_1to4.sv
// Round-robin 1-to-4 dispatcher: each accepted upstream request is loaded into
// the next available lane after the previously loaded one; lanes hold one entry.
module sal_dispatcher_rr_1to4 #(
    parameter int REQ_CNT     = 4,
    parameter int REQ_CNT_LG2 = $clog2(REQ_CNT),
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic                   gnt_o,
    output logic [REQ_CNT-1:0]     req_arr_o,
    output logic [DATA_WIDTH-1:0]  data_arr_o [0:REQ_CNT-1],
    input  logic [REQ_CNT-1:0]     gnt_arr_i,
    output logic [REQ_CNT_LG2-1:0] last_lane_o
);

    logic [REQ_CNT-1:0]     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  data_q [0:REQ_CNT-1];
    logic [DATA_WIDTH-1:0]  data_d [0:REQ_CNT-1];
    logic [REQ_CNT_LG2-1:0] prev_q, prev_d;

    logic [REQ_CNT-1:0]     avail;
    logic [REQ_CNT_LG2-1:0] target;
    logic [REQ_CNT_LG2-1:0] idx;
    logic                   found;

    always_comb begin
        // A lane draining this cycle counts as free so it can be reloaded.
        avail  = ~valid_q | gnt_arr_i;
        gnt_o  = |avail;
        target = prev_q;
        found  = 1'b0;
        idx    = prev_q;
        for (int i = 1; i <= REQ_CNT; i++) begin
            idx = prev_q + REQ_CNT_LG2'(i);
            if (!found && avail[idx]) begin
                target = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q & ~gnt_arr_i;
        data_d  = data_q;
        prev_d  = prev_q;
        if (req_i && gnt_o) begin
            valid_d[target] = 1'b1;
            data_d[target]  = data_i;
            prev_d          = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            prev_q  <= REQ_CNT_LG2'(REQ_CNT - 1);
            for (int k = 0; k < REQ_CNT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            prev_q  <= prev_d;
            for (int k = 0; k < REQ_CNT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign req_arr_o   = valid_q;
    assign data_arr_o  = data_q;
    assign last_lane_o = prev_q;

endmodule

// File: doc/sal_dispatcher_rr_1to4.md
# sal_dispatcher_rr_1to4

Round-robin dispatcher that splits one req/gnt request stream across four downstream consumers; it is the counterpart of the 4-to-1 round-robin arbiter. Each accepted request goes to the next available lane after the previously served one, and each lane holds its request in a one-entry output register until that consumer grants it. The block sits in front of replicated workers, for example four bank controllers or four processing engines fed from one command queue.

## Interface
- REQ_CNT, 4, number of downstream lanes; fixed at 4 for this block.
- REQ_CNT_LG2, $clog2(REQ_CNT), lane index width.
- DATA_WIDTH, 64, payload width.

- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- req_i  input  1  upstream request valid.
- data_i  input  DATA_WIDTH  upstream payload.
- gnt_o  output  1  upstream grant; a transfer occurs when req_i & gnt_o.
- req_arr_o  output  REQ_CNT  per-lane request valid, registered.
- data_arr_o  output  DATA_WIDTH [0:REQ_CNT-1]  per-lane payload, registered.
- gnt_arr_i  input  REQ_CNT  per-lane grant; lane k drains when req_arr_o[k] & gnt_arr_i[k].
- last_lane_o  output  REQ_CNT_LG2  index of the most recently loaded lane (the prev_target register).

## Operation
- State:
  - prev_target (REQ_CNT_LG2 bits).
  - Per lane k: valid[k] and data[k].
  - req_arr_o = valid, data_arr_o = data.
- Lane availability:
  - avail[k] = ~valid[k] | gnt_arr_i[k].
  - A lane being drained this cycle may be reloaded in the same cycle.
- Upstream grant:
  - gnt_o = |avail. It depends only on lane state and gnt_arr_i, never on req_i.
- Target selection (combinational):
  - The first k with avail[k], searching in order (prev_target+1) mod 4, +2, +3, +4 (the last step is prev_target itself).
  - Wrap-around uses mod-4 arithmetic on REQ_CNT_LG2 bits.
- On transfer (req_i & gnt_o):
  - valid[target] <= 1, data[target] <= data_i.
  - prev_target <= target.
- On drain of lane k without reload: valid[k] <= 0. data[k] holds its last value, which is don't-care while invalid.
- Draining lanes not selected as the target clear normally in the same cycle.
- Without a transfer, prev_target holds. Skipped or busy lanes do not advance the pointer.
- Data integrity:
  - Each accepted payload is presented on exactly one lane.
  - data_arr_o[k] stays stable while req_arr_o[k]=1 and gnt_arr_i[k]=0.
- No reordering guarantee across lanes. Order within one lane is trivially preserved because each lane holds one entry.

## Timing
- Reset values (asserted asynchronously, released synchronously to clk):
  - req_arr_o = 4'b0000, data_arr_o = all 0, prev_target = 3, last_lane_o = 3.
  - gnt_o = 1 after reset, since all lanes are empty. The first target is lane 0.
- Latency:
  - A payload accepted at edge N appears on req_arr_o/data_arr_o after edge N, i.e. it is visible in cycle N+1.
  - Upstream throughput is one transfer per cycle while any lane is available.
- All lanes full with no gnt_arr_i: gnt_o=0, no state change, req_i ignored.
- Lane full and drained in the same cycle it is targeted: it is reloaded, req_arr_o[k] stays 1, and the new data appears the next cycle.
- Only one lane available: it is always selected, regardless of where the pointer sits.
- Reset asserted mid-operation: buffered payloads are discarded and all outputs go to reset values immediately. A transfer in that cycle is lost.
- No combinational path from req_i or data_i to any output. gnt_o has a combinational path from gnt_arr_i.

## Test plan
- Reset, then four back-to-back requests with data 0xA0..0xA3 and gnt_arr_i=0 -> lanes 0,1,2,3 receive 0xA0..0xA3 in order, gnt_o drops to 0 after the fourth transfer, and last_lane_o=3.
- All lanes full, then gnt_arr_i=4'b0100 with req_i=1 and data 0xB0 -> lane 2 is drained and reloaded with 0xB0 in the same cycle, req_arr_o[2] stays 1, and last_lane_o=2.
- Pointer at 1 with lanes 2 and 3 full and a new request -> the target skips 2 and 3 and wraps to lane 0, so last_lane_o=0.
- Continuous req_i=1 with gnt_arr_i=4'b1111 for 8 cycles -> gnt_o stays 1, targets go 0,1,2,3,0,1,2,3, and each payload appears exactly once, one cycle after acceptance.
- Lane 1 full with gnt_arr_i[1]=0 held for 5 cycles -> data_arr_o[1] and req_arr_o[1] stay stable, and other traffic bypasses lane 1.
- rst_n asserted asynchronously mid-cycle with lanes 0 and 3 full -> req_arr_o becomes 0 immediately; after release the next request goes to lane 0.
